// File: rtl/upper_layer_tx_adapter.sv
// Word-to-byte transmit adapter: DEPTH-word FIFO feeding an LSB-first byte serializer.
// Optional build macro UPPER_LAYER_TX_STATS_EN adds the saturating bytes_sent counter.
module upper_layer_tx_adapter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int BYTES = DATA_W / 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cl0_s,
  input  logic [DATA_W-1:0] transport_layer_data_in,
  input  logic              transport_data_flag,
  output logic              enable_sending,
  output logic [7:0]        transport_layer_data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [CNT_W-1:0]  fifo_count
`ifdef UPPER_LAYER_TX_STATS_EN
  ,
  output logic [15:0]       bytes_sent
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  idx;
  state_t            state;
  logic              push;
  logic              pop;
  logic              can_pop;
  logic              last_byte_taken;

  assign enable_sending  = cl0_s && (fifo_count != FULL_CNT);
  assign push            = transport_data_flag && enable_sending;
  assign can_pop         = cl0_s && (fifo_count != '0);
  assign last_byte_taken = (state == SHIFT) && data_out_ready && (idx == LAST_IDX);
  // A pop at the last byte of a word reloads the serializer without an idle cycle.
  assign pop             = can_pop && ((state == IDLE) || last_byte_taken);

  assign transport_layer_data_out = shift_reg[7:0];

  // Word storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= transport_layer_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      idx            <= '0;
      data_out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg      <= mem[rd_ptr];
            idx            <= '0;
            state          <= SHIFT;
            data_out_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (data_out_ready) begin
            if (idx != LAST_IDX) begin
              shift_reg <= shift_reg >> 8;
              idx       <= idx + IDX_W'(1);
            end else if (pop) begin
              shift_reg <= mem[rd_ptr];
              idx       <= '0;
            end else begin
              state          <= IDLE;
              idx            <= '0;
              data_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state          <= IDLE;
          data_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef UPPER_LAYER_TX_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bytes_sent <= '0;
    end else if (data_out_valid && data_out_ready) begin
      bytes_sent <= sat_inc16(bytes_sent);
    end
  end
`endif

endmodule
